risc_v_32_wb_arbiter: RTL and testbench
=======================================

Name: risc_v_32_wb_arbiter

Overview:
Writeback arbiter for the RV32I core. It is the producer side of the register file write port (wr/wd/wreg). It merges two writeback sources onto the single write port:
- ALU results, via a valid/ready handshake.
- Load responses, valid only; these always have priority.
ALU results that cannot be written immediately are held in a small in-order FIFO.

Parameters:
DEPTH, 2, ALU FIFO entries; power of 2, >=2.
AW, 1, FIFO pointer width; must equal log2(DEPTH).

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous active-high reset.
alu_valid  input  1  ALU writeback request.
alu_ready  output  1  ALU request accepted this cycle when alu_valid&&alu_ready.
alu_rd  input  5  ALU destination register.
alu_data  input  32  ALU result.
ld_valid  input  1  load response; must be consumed this cycle, no ready.
ld_rd  input  5  load destination register.
ld_data  input  32  load data, already extended.
wr  output  5  register file write address (registered).
wd  output  32  register file write data (registered).
wreg  output  1  register file write enable (registered).
fifo_cnt  output  AW+1  ALU entries currently queued.

Behaviour:
- Reset (async, rst=1):
  - wreg=0, wr=0, wd=0.
  - FIFO pointers=0, fifo_cnt=0.
  - Any queued or in-flight entries are discarded; no write occurs after reset asserts.
- Ready: alu_ready = (fifo_cnt < DEPTH). It is a function of registered state only and never depends on ld_valid or alu_valid.
- Output selection per cycle, in priority order:
  1. ld_valid=1: load wins.
     - If ld_rd!=0: next-cycle wr=ld_rd, wd=ld_data, wreg=1.
     - If ld_rd==0: wreg=0 next cycle.
  2. Else fifo_cnt>0: pop head; next-cycle wr/wd=head, wreg=1.
  3. Else an accepted ALU request with alu_rd!=0 bypasses the FIFO; next-cycle wr/wd=alu_rd/alu_data, wreg=1; not enqueued.
  4. Else wreg=0; wr/wd hold their previous values.
- Enqueue: an accepted ALU request that is not bypassed and has alu_rd!=0 is written at the tail.
  - Simultaneous pop and push in one cycle: fifo_cnt unchanged.
- x0 filtering: accepted ALU requests with alu_rd==0 are consumed and dropped. They are neither stored nor written, and fifo_cnt is unchanged.
- Latency: one cycle from the accepting or selecting edge to wreg. Exactly one write per cycle maximum.
- Ordering:
  - ALU results retire in acceptance order.
  - Bypass only when the FIFO is empty, so order is preserved.
  - No ordering between the load and ALU sources; the issue stage guarantees no two outstanding writes to the same rd across sources.
- Pointers wrap modulo DEPTH. Full is fifo_cnt==DEPTH; empty is fifo_cnt==0.
- Full with a load present: no pop, no accept, contents held.
- Full without a load: pop occurs; alu_ready is still 0 that cycle and rises next cycle.
- Sustained ld_valid starves the FIFO indefinitely; this is permitted.
- Illegal alu_valid while !alu_ready: ignored; the request must be held by the source.
- rst asserted mid-stream: outputs clear immediately (async). The first possible write is in the cycle after rst deasserts, plus one.

Optional Feature:
RISC_V_32_WB_STALL_CNT_EN.
- Defined: adds output stall_cnt [31:0], reset to 0. It increments by 1 each cycle where (alu_valid && !alu_ready) or (ld_valid && fifo_cnt>0). It saturates at 32'hFFFFFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then ld_valid=1 with ld_rd=5, ld_data=32'hDEADBEEF for one cycle -> next cycle wreg=1, wr=5, wd=32'hDEADBEEF; the cycle after, wreg=0.
- FIFO empty, alu_valid with rd=3, data=7, no load -> bypass; next cycle wr=3, wd=7; fifo_cnt stays 0.
- ld_valid held 3 cycles while ALU pushes rd=1..3 (DEPTH=2):
  - Entries rd=1 and rd=2 queue; fifo_cnt=2; alu_ready=0; rd=3 is held by the source.
  - After the load drops, writes appear in order rd=1, 2, 3 on consecutive cycles.
- ALU rd=0, data=9 and load rd=0 -> both consumed, wreg never asserts, fifo_cnt=0.
- Queue 2 entries, assert rst asynchronously mid-cycle -> wreg=0 immediately, fifo_cnt=0; after release no stale write appears.
- With RISC_V_32_WB_STALL_CNT_EN: 4 cycles of alu_valid against a full FIFO under continuous load -> stall_cnt=4 (plus the load-vs-nonempty cycles counted once per cycle, not twice).

Source files
------------

// File: rtl/risc_v_32_wb_arbiter.sv
// Writeback arbiter: merges load responses (priority) and ALU results (valid/ready, FIFO-buffered)
// onto the register file write port. Define RISC_V_32_WB_STALL_CNT_EN to add the stall_cnt output.
module risc_v_32_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [4:0]    alu_rd,
  input  logic [31:0]   alu_data,
  input  logic          ld_valid,
  input  logic [4:0]    ld_rd,
  input  logic [31:0]   ld_data,
  output logic [4:0]    wr,
  output logic [31:0]   wd,
  output logic          wreg,
`ifdef RISC_V_32_WB_STALL_CNT_EN
  output logic [31:0]   stall_cnt,
`endif
  output logic [AW:0]   fifo_cnt
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [36:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  logic fifo_empty;
  logic accept;
  logic pop;
  logic bypass;
  logic push;

  assign fifo_empty = (fifo_cnt == '0);
  assign alu_ready  = (fifo_cnt < FULL_CNT);
  assign accept     = alu_valid && alu_ready;
  assign pop        = !ld_valid && !fifo_empty;
  // Bypass only with an empty FIFO so ALU results keep acceptance order.
  assign bypass     = !ld_valid && fifo_empty && accept && (alu_rd != 5'd0);
  assign push       = accept && (alu_rd != 5'd0) && !bypass;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {alu_rd, alu_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + (AW+1)'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr   <= '0;
      wd   <= '0;
      wreg <= 1'b0;
    end else if (ld_valid) begin
      wreg <= (ld_rd != 5'd0);
      if (ld_rd != 5'd0) begin
        wr <= ld_rd;
        wd <= ld_data;
      end
    end else if (pop) begin
      wreg <= 1'b1;
      wr   <= mem[rptr][36:32];
      wd   <= mem[rptr][31:0];
    end else if (bypass) begin
      wreg <= 1'b1;
      wr   <= alu_rd;
      wd   <= alu_data;
    end else begin
      wreg <= 1'b0;
    end
  end

`ifdef RISC_V_32_WB_STALL_CNT_EN
  logic stall_ev;
  assign stall_ev = (alu_valid && !alu_ready) || (ld_valid && !fifo_empty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              stall_cnt <= '0;
    else if (stall_ev && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_risc_v_32_wb_arbiter.sv
// Directed bench for risc_v_32_wb_arbiter; expected writes are queued as stimulus is driven
// and popped by a negedge monitor whenever the DUT asserts wreg.
module tb_risc_v_32_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [4:0]  wr;
  logic [31:0] wd;
  logic        wreg;
  logic [1:0]  fifo_cnt;
`ifdef RISC_V_32_WB_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  risc_v_32_wb_arbiter #(.DEPTH(2), .AW(1)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .wr(wr), .wd(wd), .wreg(wreg),
`ifdef RISC_V_32_WB_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [4:0] rd; logic [31:0] d; } wb_t;
  wb_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int n_exp = 0;
  int n_writes = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back('{rd: rd, d: d});
    n_exp++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && wreg === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(wreg), 64'd0);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        check("wr", 64'(wr), 64'(e.rd));
        check("wd", 64'(wd), 64'(e.d));
      end
    end
  end

  initial begin
    int idx;
    logic acc;
    rst = 1'b1; alu_valid = 0; alu_rd = 0; alu_data = 0; ld_valid = 0; ld_rd = 0; ld_data = 0;
    #1;
    check("rst_wreg", 64'(wreg), 64'd0);
    check("rst_wr", 64'(wr), 64'd0);
    check("rst_wd", 64'(wd), 64'd0);
    check("rst_cnt", 64'(fifo_cnt), 64'd0);
    check("rst_ready", 64'(alu_ready), 64'd1);
    cyc();
    rst = 1'b0;

    // Single load write
    ld_valid = 1; ld_rd = 5; ld_data = 32'hDEADBEEF;
    expect_wr(5'd5, 32'hDEADBEEF);
    cyc();
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    check("ld_wreg", 64'(wreg), 64'd1);
    cyc();
    check("ld_wreg_clr", 64'(wreg), 64'd0);

    // ALU bypass on empty FIFO
    alu_valid = 1; alu_rd = 3; alu_data = 7;
    expect_wr(5'd3, 32'd7);
    cyc();
    alu_valid = 0;
    check("byp_wreg", 64'(wreg), 64'd1);
    check("byp_cnt", 64'(fifo_cnt), 64'd0);
    cyc();

    // Loads held 3 cycles while ALU offers rd=1..3
    expect_wr(5'd10, 32'hA0); expect_wr(5'd11, 32'hA1); expect_wr(5'd12, 32'hA2);
    expect_wr(5'd1, 32'h101); expect_wr(5'd2, 32'h102); expect_wr(5'd3, 32'h103);
    idx = 1;
    for (int c = 0; c < 7; c++) begin
      ld_valid = (c < 3);
      ld_rd    = 5'(10 + c);
      ld_data  = 32'hA0 + 32'(c);
      alu_valid = (idx <= 3);
      alu_rd    = 5'(idx);
      alu_data  = 32'h100 + 32'(idx);
      if (c == 2) begin
        check("q_cnt_full", 64'(fifo_cnt), 64'd2);
        check("q_ready_low", 64'(alu_ready), 64'd0);
      end
      acc = alu_valid && alu_ready;
      cyc();
      if (acc) idx++;
    end
    alu_valid = 0; ld_valid = 0;
    check("q_cnt_drain", 64'(fifo_cnt), 64'd0);

    // x0 from both sources
    alu_valid = 1; alu_rd = 0; alu_data = 9;
    ld_valid = 1; ld_rd = 0; ld_data = 32'h55;
    cyc();
    alu_valid = 0; ld_valid = 0;
    check("x0_wreg", 64'(wreg), 64'd0);
    check("x0_cnt", 64'(fifo_cnt), 64'd0);
    cyc();
    check("x0_wreg2", 64'(wreg), 64'd0);

    // Queue two entries behind rd0 loads, then reset mid-cycle
    ld_valid = 1; ld_rd = 0; ld_data = 32'h1;
    alu_valid = 1; alu_rd = 4; alu_data = 32'h44;
    cyc();
    alu_rd = 5; alu_data = 32'h55;
    cyc();
    check("pre_rst_cnt", 64'(fifo_cnt), 64'd2);
    alu_valid = 0; ld_valid = 0;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_wreg", 64'(wreg), 64'd0);
    check("mid_rst_cnt", 64'(fifo_cnt), 64'd0);
    check("mid_rst_wr", 64'(wr), 64'd0);
    cyc();
    rst = 1'b0;
    repeat (4) cyc();
    check("post_rst_cnt", 64'(fifo_cnt), 64'd0);

    // Full FIFO under continuous load, then drain with a held ALU request
    ld_valid = 1; ld_rd = 0; ld_data = 0;
    alu_valid = 1; alu_rd = 6; alu_data = 32'h66;
    cyc();
    alu_rd = 7; alu_data = 32'h77;
    cyc();
    alu_rd = 8; alu_data = 32'h88;
    repeat (4) cyc();
    check("full_cnt", 64'(fifo_cnt), 64'd2);
`ifdef RISC_V_32_WB_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'd5);
`endif
    expect_wr(5'd6, 32'h66); expect_wr(5'd7, 32'h77); expect_wr(5'd8, 32'h88);
    ld_valid = 0;
    check("full_pop_ready", 64'(alu_ready), 64'd0);
    cyc();
    check("after_pop_ready", 64'(alu_ready), 64'd1);
    check("after_pop_cnt", 64'(fifo_cnt), 64'd1);
    cyc();
    alu_valid = 0;
    check("swap_cnt", 64'(fifo_cnt), 64'd1);
    repeat (3) cyc();
    check("final_cnt", 64'(fifo_cnt), 64'd0);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("write_count", 64'(n_writes), 64'(n_exp));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
